fp_result_encoder: RTL and testbench
====================================

FP_RESULT_ENCODER -- requirements
Module: fp_result_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  divider result available (driven from divider ready/DONE).
REQ-004 SHALL have ports: in_ready  out  1  encoder can accept a result.
REQ-005 SHALL have ports: mode_fp  in  1  0=half, 1=single; sampled at acceptance.
REQ-006 SHALL have ports: in_sign, in_exp[7:0], in_mant[22:0]  in  1/8/23  divider result, exponent in single-precision bias (127).
REQ-007 SHALL have ports: in_overflow, in_underflow, in_inexact  in  1 each  divider flags.
REQ-008 SHALL have ports: out_valid  out  1; out_ack  in  1; result  out  32  packed word; flag_overflow, flag_underflow, flag_inexact  out  1 each.

Function
REQ-009 SHALL accept inputs only on a cycle with in_valid=1 and in_ready=1, registering all inputs including mode_fp.
REQ-010 SHALL run FSM IDLE->ALIGN->ROUND->DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-011 SHALL assert out_valid exactly 3 cycles after the acceptance edge.
REQ-012 SHALL hold result and flags stable in DONE until out_ack=1, then return to IDLE next cycle; out_ack outside DONE ignored.
REQ-013 Single mode SHALL output {sign,exp,mant}; in_exp=0xFF forces mant=0 (infinity); no rounding, flags = input flags.
REQ-014 Half mode SHALL compute e_h = in_exp - 112 (9-bit signed), output in result[15:0], result[31:16]=0.
REQ-015 Half normal (1<=e_h<=30): mant_h = in_mant[22:13], guard=in_mant[12], sticky=|in_mant[11:0] | in_inexact; round-to-nearest-even.
REQ-016 Rounding carry out of mant_h SHALL increment exponent; reaching 31 yields infinity.
REQ-017 Half overflow (e_h>=31 or carry to 31 or in_overflow): result[15:0]={sign,5'h1F,10'h0}, flag_overflow=1, flag_inexact=1.
REQ-018 Half tiny (e_h<=0, in_exp>0): significand {1,in_mant} shifted right by 126-in_exp, guard/sticky from shifted-out bits plus in_inexact, RNE; carry into 0x0400 encodes min normal.
REQ-019 Shift >=25 SHALL yield signed zero, flag_inexact=1, flag_underflow=1.
REQ-020 flag_underflow SHALL be (tiny AND inexact) OR in_underflow; flag_inexact SHALL be guard|sticky OR in_inexact.
REQ-021 in_exp=0 in half mode SHALL yield signed zero, flags = input flags.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, all flags=0, regardless of state.
REQ-023 An operation interrupted by reset SHALL be discarded; no out_valid after rst_n release without a new acceptance.

Configuration
REQ-024 With FP_ENC_FLAGS_STICKY_EN defined, flag outputs SHALL be sticky: OR-accumulated across operations, cleared only by reset.
REQ-025 Without FP_ENC_FLAGS_STICKY_EN, flags SHALL reflect only the current result and clear on leaving DONE.

Verification
REQ-026 Single: sign=0, exp=0x80, mant=0x400000 -> 3 cycles later out_valid, result=0x40400000, flags 0.
REQ-027 Half RNE: exp=0x7F, mant=0x001000 -> 0x00003C00, inexact=1; mant=0x003000 -> 0x00003C02, inexact=1.
REQ-028 Half overflow: exp=0x8F, mant=0 -> 0x00007C00, overflow=1; exp=0x8E, mant=0x7FF000 -> 0x00007C00, overflow=1.
REQ-029 Half subnormal: exp=0x70, mant=0 -> 0x00000200, underflow=0; exp=0x67, mant=0 -> 0x00000001; exp=0x60 -> 0x00000000, underflow=1, inexact=1.
REQ-030 Handshake: hold out_ack=0 for 5 cycles -> result stable, in_ready=0; out_ack=1 -> in_ready=1 next cycle.
REQ-031 Reset in ALIGN -> outputs zero at once, no out_valid afterwards; with FP_ENC_FLAGS_STICKY_EN, overflow then clean op -> flag_overflow remains 1.

Source files
------------

// File: rtl/fp_result_encoder.sv
// Packs a divider result into IEEE single or half precision (RNE rounding for half).
// Optional macro FP_ENC_FLAGS_STICKY_EN makes the flag outputs accumulate until reset.
module fp_result_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode_fp,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [22:0] in_mant,
  input  logic        in_overflow,
  input  logic        in_underflow,
  input  logic        in_inexact,
  output logic        out_valid,
  input  logic        out_ack,
  output logic [31:0] result,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact,
  output logic [1:0]  dbg_state
);

  // Handshake: a result is taken on a rising edge where in_valid && in_ready;
  // the packed word is offered while out_valid and retired on an edge with out_ack.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] CLS_RND  = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_OVF  = 2'd2;

  logic [1:0]  state;
  logic        cap_mode, cap_sign, cap_ovf, cap_unf, cap_inx;
  logic [7:0]  cap_exp;
  logic [22:0] cap_mant;

  logic [1:0]  al_cls;
  logic [14:0] al_pre;
  logic        al_guard, al_sticky, al_tiny;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  // Alignment: half exponent rebias and subnormal denormalisation.
  logic signed [8:0] e_h;
  logic [7:0]        sh;
  logic [47:0]       wide;
  logic [1:0]        cls_n;
  logic [14:0]       pre_n;
  logic              guard_n, sticky_n, tiny_n;
  logic              unused_wide;

  assign e_h         = $signed({1'b0, cap_exp}) - 9'sd112;
  assign sh          = 8'd126 - cap_exp;
  assign wide        = {1'b1, cap_mant, 24'b0} >> sh[4:0];
  assign unused_wide = ^wide[47:34];

  always_comb begin
    cls_n    = CLS_RND;
    pre_n    = '0;
    guard_n  = 1'b0;
    sticky_n = 1'b0;
    tiny_n   = 1'b0;
    if (cap_exp == 8'd0) begin
      cls_n = CLS_ZERO;
    end else if (cap_ovf || (e_h > 9'sd30)) begin
      cls_n = CLS_OVF;
    end else if (e_h >= 9'sd1) begin
      pre_n    = {e_h[4:0], cap_mant[22:13]};
      guard_n  = cap_mant[12];
      sticky_n = (|cap_mant[11:0]) | cap_inx;
    end else begin
      tiny_n = 1'b1;
      // Everything shifted past the guard position: pure sticky, rounds to zero.
      if (sh >= 8'd25) begin
        sticky_n = 1'b1;
      end else begin
        pre_n    = {5'b0, wide[33:24]};
        guard_n  = wide[23];
        sticky_n = (|wide[22:0]) | cap_inx;
      end
    end
  end

  // Rounding and final packing.
  logic        round_up, inexact_r;
  logic [14:0] rounded;
  logic [31:0] res_n;
  logic        ovf_n, unf_n, inx_n;

  assign round_up  = al_guard & (al_sticky | al_pre[0]);
  assign rounded   = al_pre + {14'b0, round_up};
  assign inexact_r = al_guard | al_sticky | cap_inx;

  always_comb begin
    res_n = '0;
    ovf_n = cap_ovf;
    unf_n = cap_unf;
    inx_n = cap_inx;
    if (cap_mode) begin
      res_n = {cap_sign, cap_exp, (cap_exp == 8'hFF) ? 23'b0 : cap_mant};
    end else begin
      case (al_cls)
        CLS_ZERO: res_n = {16'b0, cap_sign, 15'b0};
        CLS_OVF: begin
          res_n = {16'b0, cap_sign, 5'h1F, 10'h0};
          ovf_n = 1'b1;
          inx_n = 1'b1;
        end
        default: begin
          // A rounding carry into exponent 31 is an overflow to infinity.
          if (!al_tiny && (rounded[14:10] == 5'h1F)) begin
            res_n = {16'b0, cap_sign, 5'h1F, 10'h0};
            ovf_n = 1'b1;
            inx_n = 1'b1;
          end else begin
            res_n = {16'b0, cap_sign, rounded};
            ovf_n = 1'b0;
            inx_n = inexact_r;
            unf_n = (al_tiny & inexact_r) | cap_unf;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cap_mode       <= 1'b0;
      cap_sign       <= 1'b0;
      cap_exp        <= '0;
      cap_mant       <= '0;
      cap_ovf        <= 1'b0;
      cap_unf        <= 1'b0;
      cap_inx        <= 1'b0;
      al_cls         <= CLS_RND;
      al_pre         <= '0;
      al_guard       <= 1'b0;
      al_sticky      <= 1'b0;
      al_tiny        <= 1'b0;
      result         <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cap_mode <= mode_fp;
            cap_sign <= in_sign;
            cap_exp  <= in_exp;
            cap_mant <= in_mant;
            cap_ovf  <= in_overflow;
            cap_unf  <= in_underflow;
            cap_inx  <= in_inexact;
            state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          al_cls    <= cls_n;
          al_pre    <= pre_n;
          al_guard  <= guard_n;
          al_sticky <= sticky_n;
          al_tiny   <= tiny_n;
          state     <= S_ROUND;
        end
        S_ROUND: begin
          result <= res_n;
`ifdef FP_ENC_FLAGS_STICKY_EN
          flag_overflow  <= flag_overflow  | ovf_n;
          flag_underflow <= flag_underflow | unf_n;
          flag_inexact   <= flag_inexact   | inx_n;
`else
          flag_overflow  <= ovf_n;
          flag_underflow <= unf_n;
          flag_inexact   <= inx_n;
`endif
          state <= S_DONE;
        end
        default: begin
          if (out_ack) begin
            state <= S_IDLE;
`ifndef FP_ENC_FLAGS_STICKY_EN
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_result_encoder.sv
// Directed-vector bench for fp_result_encoder: table of hand-computed encodings
// plus handshake, reset-abort and flag-retention sequences.
module tb_fp_result_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mode_fp, in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_mant;
  logic        in_overflow, in_underflow, in_inexact;
  logic        out_valid, out_ack;
  logic [31:0] result;
  logic        flag_overflow, flag_underflow, flag_inexact;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fp_result_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode_fp(mode_fp), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_overflow(in_overflow), .in_underflow(in_underflow), .in_inexact(in_inexact),
    .out_valid(out_valid), .out_ack(out_ack), .result(result),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
    .flag_inexact(flag_inexact), .dbg_state(dbg_state)
  );

  // fl is {overflow, underflow, inexact}
  typedef struct packed {
    logic        mode;
    logic        sign;
    logic [7:0]  e8;
    logic [22:0] m;
    logic [2:0]  fin;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  localparam int NV = 18;
  vec_t        vecs [NV];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [2:0]  acc_fl = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {29'b0, flag_overflow, flag_underflow, flag_inexact};
  endfunction

  task automatic start_op(input vec_t v);
    @(negedge clk);
    mode_fp      = v.mode;
    in_sign      = v.sign;
    in_exp       = v.e8;
    in_mant      = v.m;
    in_overflow  = v.fin[2];
    in_underflow = v.fin[1];
    in_inexact   = v.fin[0];
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic finish_op(input int idx, input vec_t v);
    logic [2:0] efl;
    efl = v.fl;
`ifdef FP_ENC_FLAGS_STICKY_EN
    acc_fl = acc_fl | v.fl;
    efl    = acc_fl;
`endif
    exp_q.push_back(v.res);
    @(posedge clk);
    #1;
    check($sformatf("early_valid[%0d]", idx), {31'b0, out_valid}, 32'd0);
    // out_valid rises on the third edge counting the acceptance edge
    @(posedge clk);
    #1;
    check($sformatf("valid[%0d]", idx), {31'b0, out_valid}, 32'd1);
    check($sformatf("result[%0d]", idx), result, exp_q.pop_front());
    check($sformatf("flags[%0d]", idx), flags_now(), {29'b0, efl});
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    check($sformatf("ready_after_ack[%0d]", idx), {31'b0, in_ready, out_valid}, 32'd2);
`ifdef FP_ENC_FLAGS_STICKY_EN
    check($sformatf("flags_after_ack[%0d]", idx), flags_now(), {29'b0, acc_fl});
`else
    check($sformatf("flags_after_ack[%0d]", idx), flags_now(), 32'd0);
`endif
  endtask

  initial begin
    //         mode sign  exp    mant        fin     result         fl
    vecs[0]  = {1'b1, 1'b0, 8'h80, 23'h400000, 3'b000, 32'h40400000, 3'b000};
    vecs[1]  = {1'b1, 1'b1, 8'hFF, 23'h123456, 3'b001, 32'hFF800000, 3'b001};
    vecs[2]  = {1'b1, 1'b0, 8'h3F, 23'h7FFFFF, 3'b010, 32'h1FFFFFFF, 3'b010};
    vecs[3]  = {1'b0, 1'b0, 8'h7F, 23'h001000, 3'b000, 32'h00003C00, 3'b001};
    vecs[4]  = {1'b0, 1'b0, 8'h7F, 23'h003000, 3'b000, 32'h00003C02, 3'b001};
    vecs[5]  = {1'b0, 1'b0, 8'h8F, 23'h000000, 3'b000, 32'h00007C00, 3'b101};
    vecs[6]  = {1'b0, 1'b0, 8'h8E, 23'h7FF000, 3'b000, 32'h00007C00, 3'b101};
    vecs[7]  = {1'b0, 1'b0, 8'h70, 23'h000000, 3'b000, 32'h00000200, 3'b000};
    vecs[8]  = {1'b0, 1'b0, 8'h67, 23'h000000, 3'b000, 32'h00000001, 3'b000};
    vecs[9]  = {1'b0, 1'b0, 8'h60, 23'h000000, 3'b000, 32'h00000000, 3'b011};
    vecs[10] = {1'b0, 1'b1, 8'h00, 23'h000005, 3'b001, 32'h00008000, 3'b001};
    vecs[11] = {1'b0, 1'b0, 8'h7F, 23'h000000, 3'b100, 32'h00007C00, 3'b101};
    vecs[12] = {1'b0, 1'b0, 8'h7F, 23'h001001, 3'b000, 32'h00003C01, 3'b001};
    vecs[13] = {1'b0, 1'b0, 8'h7F, 23'h001000, 3'b001, 32'h00003C01, 3'b001};
    vecs[14] = {1'b0, 1'b0, 8'h70, 23'h7FFFFF, 3'b000, 32'h00000400, 3'b011};
    vecs[15] = {1'b0, 1'b1, 8'h66, 23'h000001, 3'b000, 32'h00008001, 3'b011};
    vecs[16] = {1'b0, 1'b0, 8'h71, 23'h000000, 3'b000, 32'h00000400, 3'b000};
    vecs[17] = {1'b0, 1'b1, 8'h80, 23'h400000, 3'b000, 32'h0000C200, 3'b000};

    rst_n = 1'b0; in_valid = 1'b0; out_ack = 1'b0; mode_fp = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_mant = '0; in_overflow = 1'b0; in_underflow = 1'b0; in_inexact = 1'b0;
    #12;
    check("reset_ready_valid", {30'b0, in_ready, out_valid}, 32'd2);
    check("reset_result", result, 32'd0);
    check("reset_flags", flags_now(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i]);
      finish_op(i, vecs[i]);
    end

    // Stall in DONE: result held, new input attempts ignored
    start_op(vecs[0]);
    @(negedge clk);
    in_valid = 1'b1;
    in_exp   = 8'h01;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    check("stall_result0", result, 32'h40400000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_result[%0d]", k), result, 32'h40400000);
      check($sformatf("stall_hs[%0d]", k), {30'b0, in_ready, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    check("stall_release", {30'b0, in_ready, out_valid}, 32'd2);

    // out_ack while idle is ignored
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    check("idle_ack", {30'b0, in_ready, out_valid}, 32'd2);

    // Overflow followed by a clean operation
    start_op(vecs[5]);
    finish_op(100, vecs[5]);
    start_op(vecs[7]);
    finish_op(101, vecs[7]);
`ifdef FP_ENC_FLAGS_STICKY_EN
    check("ovf_retained", {31'b0, flag_overflow}, 32'd1);
`else
    check("ovf_cleared", {31'b0, flag_overflow}, 32'd0);
`endif

    // Reset during ALIGN discards the operation
    start_op(vecs[4]);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready_valid", {30'b0, in_ready, out_valid}, 32'd2);
    check("abort_result", result, 32'd0);
    check("abort_flags", flags_now(), 32'd0);
    acc_fl = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_no_valid[%0d]", k), {31'b0, out_valid}, 32'd0);
    end

    // Encoder still works after the aborted operation
    start_op(vecs[3]);
    finish_op(102, vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
